mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single MIG user interface (ui_clk domain) between two requesters, e.g. the GBA cartridge-bus front end and the host loader. Performs round-robin arbitration, 128-bit burst alignment with byte-lane placement and write masking, and in-order routing of read data back to the issuing requester through a read-tag FIFO. Sits between the requesters and the `sdram` MIG instance, replacing the direct mux-to-app wiring.

## Interface
Parameters:
- `ADDR_WIDTH`, 29: MIG `app_addr` width.
- `REQ_ADDR_WIDTH`, 26: requester byte-address width.
- `TAG_DEPTH`, 4: maximum outstanding reads (power of two).

Ports (requester arrays indexed `[1:0]`, index 0 = requester 0):
- `clk` in 1: ui_clk. One clock only.
- `rst` in 1: synchronous, active-high; driven from `rst_ui_sync`.
- `calib_done` in 1: MIG `init_calib_complete`.
- `rq_valid` in [1:0]: request valid, held stable until `rq_ready`.
- `rq_wr` in [1:0]: 1 = write, 0 = read.
- `rq_addr` in [1:0][REQ_ADDR_WIDTH-1:0]: byte address.
- `rq_width` in [1:0][1:0]: 00 = none, 01 = 8-bit, 10 = 16-bit, 11 = 32-bit.
- `rq_wr_data` in [1:0][31:0]: write data, right-justified.
- `rq_ready` out [1:0]: request accepted this cycle.
- `rs_valid` out [1:0]: read response for that requester, one-cycle pulse.
- `rs_data` out 32: read data, qualified by `rs_valid`.
- `app_addr` out ADDR_WIDTH; `app_cmd` out 3; `app_en` out 1; `app_rdy` in 1.
- `app_wdf_data` out 128; `app_wdf_mask` out 16; `app_wdf_wren` out 1; `app_wdf_end` out 1; `app_wdf_rdy` in 1.
- `app_rd_data` in 128; `app_rd_data_valid` in 1.
- `err_orphan` out 1: sticky; read data arrived with no outstanding tag.

## Operation
- **Address alignment**
  - Address is forced to natural alignment: 16-bit clears bit 0; 32-bit clears bits 1:0.
  - `off = addr[3:0]`.
  - `app_addr = {zero-pad, addr[25:4], 3'b000}`.
- **Write placement**
  - Memory byte `off+k` holds requester byte k.
  - 8-bit: k0 = `wr_data[7:0]`.
  - 16-bit: k0 = `[15:8]`, k1 = `[7:0]`.
  - 32-bit: k0 = `[31:24]` … k3 = `[7:0]`.
  - `app_wdf_mask` bit is 0 only for written lanes. Width 00 gives mask `16'hFFFF`; the command is still issued.
- **Read extraction**
  - `bk = app_rd_data[8*(off+k)+:8]`.
  - 8-bit: `rs_data = {b0,24'h0}`.
  - 16-bit: `{b0,b1,16'h0}`.
  - 32-bit: `{b0,b1,b2,b3}`.
  - Width 00: `32'h0`.
- **Arbitration**
  - Round-robin. `last` records the last granted requester; the other requester has priority next.
  - `last` is 1 after reset, so requester 0 wins first.
- **FSM states**
  - IDLE: `rq_ready[g]` is asserted combinationally when all of the following hold:
    - `calib_done` is 1;
    - `rq_valid[g]` is 1 and `g` is the winner;
    - the request is a write, or the tag FIFO is not full.
    - On acceptance the request is captured and the FSM goes to RD or WR.
  - RD: `app_en=1`, `app_cmd=3'b001`, held until `app_rdy`. On acceptance, push tag {id, off, width} and return to IDLE.
  - WR: `app_en` and `app_wdf_wren`/`app_wdf_end` are driven together, with independent done flags.
    - `app_en` drops once `app_rdy` has been seen.
    - `wren` drops once `app_wdf_rdy` has been seen.
    - Return to IDLE in the cycle both are done; either order, or both together, is legal.
- **Response path**
  - On `app_rd_data_valid`, pop a tag. Next cycle, pulse `rs_valid[id]` with the extracted `rs_data`.
  - If `app_rd_data_valid` arrives with the FIFO empty: discard the data, set `err_orphan`.
  - A push and a pop in the same cycle is legal; occupancy is unchanged.

## Timing
- Reset values:
  - all `rq_ready`, `rs_valid`, `app_en`, `app_wdf_wren`, `app_wdf_end` = 0;
  - `app_cmd`, `app_addr`, `app_wdf_data`, `rs_data` = 0;
  - `app_wdf_mask` = `16'hFFFF`;
  - `err_orphan` = 0, FSM = IDLE, tag FIFO empty, `last` = 1.
- Accept at cycle T → `app_en` at T+1 earliest.
- Minimum request spacing is 2 cycles (IDLE, then RD or WR).
- Response: `rs_valid` at cycle V+1 for `app_rd_data_valid` at cycle V.
- App outputs are registered and stable while `app_en` or `wren` is held.
- `calib_done` falling mid-request: the in-flight command still completes; no new accepts.
- `rst` mid-operation: return to reset state at once; outstanding tags are dropped.

## Structure
- Package `mem_pkg`:
  - width codes `DATA_WIDTH_0/8/16/32`;
  - `CMD_READ` = 3'b001, `CMD_WRITE` = 3'b000;
  - `rd_tag_t` {id, off[3:0], width[1:0]};
  - FSM state enum.
- Sub-module `mem_rd_tag_fifo`: synchronous FIFO of `rd_tag_t`, depth `TAG_DEPTH`, with full/empty and simultaneous push/pop.

## Test plan
- **Byte write, then 32-bit read.** Req0 writes 8-bit `0xAB` at `0x13`; WR drives `app_addr=0x10`, mask `16'hFFF7`, lane 3 = `0xAB`. A 32-bit read at `0x10` with stub data lane 3 = `0xAB` returns `rs_data[7:0]=0xAB`.
- **16-bit placement and alignment.** 16-bit write `0x1234` at `0x0F` aligns to `0x0E`; lane 14 = `0x12`, lane 15 = `0x34`, mask `16'h3FFF`.
- **Contention.** Both requesters valid continuously: grants alternate 0,1,0,1; `app_en` never asserted while `calib_done=0`.
- **Tag ordering and backpressure.** Four reads issued with `app_rdy` stalls; a fifth read is stalled (`rq_ready=0`) until one pop. Responses return in issue order to the correct `rs_valid` bit.
- **Write handshake skew.** `app_wdf_rdy` accepted 3 cycles before `app_rdy`: `wren` drops after 1 cycle, `app_en` is held, WR exits when `app_rdy` arrives. Repeat with the reverse order.
- **Orphan read and reset.** `app_rd_data_valid` with no outstanding tag sets `err_orphan`, and no `rs_valid` is pulsed. Then `rst` during RD: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg: shared types and lane helpers for the MIG request arbiter       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_pkg;

  localparam logic [1:0] DATA_WIDTH_0  = 2'b00;
  localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
  localparam logic [1:0] DATA_WIDTH_16 = 2'b10;
  localparam logic [1:0] DATA_WIDTH_32 = 2'b11;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  typedef struct packed {
    logic       id;
    logic [3:0] off;
    logic [1:0] width;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      DATA_WIDTH_8:  return 3'd1;
      DATA_WIDTH_16: return 3'd2;
      DATA_WIDTH_32: return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] align_off(input logic [3:0] off, input logic [1:0] width);
    case (width)
      DATA_WIDTH_16: return {off[3:1], 1'b0};
      DATA_WIDTH_32: return {off[3:2], 2'b00};
      default:       return off;
    endcase
  endfunction

  // Requester byte k is taken MSB-first from the right-justified word and lands in lane off+k.
  function automatic logic [127:0] place_data(input logic [3:0] off, input logic [1:0] width,
                                              input logic [31:0] data);
    logic [127:0] lanes;
    logic [2:0]   n;
    logic [3:0]   lane;
    logic [1:0]   src;
    lanes = '0;
    n     = width_bytes(width);
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n) begin
        lane = off + 4'(k);
        src  = 2'(n - 3'(k) - 3'd1);
        lanes[{lane, 3'b000} +: 8] = data[{src, 3'b000} +: 8];
      end
    end
    return lanes;
  endfunction

  function automatic logic [15:0] place_mask(input logic [3:0] off, input logic [1:0] width);
    logic [15:0] m;
    logic [2:0]  n;
    m = '1;
    n = width_bytes(width);
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n) m[off + 4'(k)] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] extract_data(input logic [127:0] rd, input logic [3:0] off,
                                               input logic [1:0] width);
    logic [31:0] r;
    logic [2:0]  n;
    logic [3:0]  lane;
    logic [1:0]  dst;
    r = '0;
    n = width_bytes(width);
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n) begin
        lane = off + 4'(k);
        dst  = 2'(3 - k);
        r[{dst, 3'b000} +: 8] = rd[{lane, 3'b000} +: 8];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rd_tag_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_rd_tag_fifo: in-order tag store for outstanding MIG reads            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_rd_tag_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign tag_o   = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= tag_i;
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: round-robin share of one MIG user port between two masters  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 29,
  parameter int REQ_ADDR_WIDTH = 26,
  parameter int TAG_DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           calib_done,
  input  logic [1:0]                     rq_valid,
  input  logic [1:0]                     rq_wr,
  input  logic [1:0][REQ_ADDR_WIDTH-1:0] rq_addr,
  input  logic [1:0][1:0]                rq_width,
  input  logic [1:0][31:0]               rq_wr_data,
  output logic [1:0]                     rq_ready,
  output logic [1:0]                     rs_valid,
  output logic [31:0]                    rs_data,
  output logic [ADDR_WIDTH-1:0]          app_addr,
  output logic [2:0]                     app_cmd,
  output logic                           app_en,
  input  logic                           app_rdy,
  output logic [127:0]                   app_wdf_data,
  output logic [15:0]                    app_wdf_mask,
  output logic                           app_wdf_wren,
  output logic                           app_wdf_end,
  input  logic                           app_wdf_rdy,
  input  logic [127:0]                   app_rd_data,
  input  logic                           app_rd_data_valid,
  output logic                           err_orphan
);

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    en_q, en_d;
  logic                    wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [127:0]            wdata_q, wdata_d;
  logic [15:0]             mask_q, mask_d;
  rd_tag_t                 tag_q, tag_d;
  logic [1:0]              rs_valid_q, rs_valid_d;
  logic [31:0]             rs_data_q, rs_data_d;
  logic                    orphan_q, orphan_d;

  logic                    win;
  logic [3:0]              win_off;
  logic                    grant;
  logic                    tag_push;
  logic                    tag_pop;
  logic                    tag_full;
  logic                    tag_empty;
  logic [TAG_W-1:0]        pop_bits;
  rd_tag_t                 pop_tag;

  // With both requesting, the one not granted last time wins; otherwise whoever is valid.
  assign win     = (rq_valid == 2'b11) ? ~last_q : rq_valid[1];
  assign win_off = align_off(rq_addr[win][3:0], rq_width[win]);
  assign grant   = !rst && calib_done && (state_q == ST_IDLE) && rq_valid[win] &&
                   (rq_wr[win] || !tag_full);
  assign tag_pop = app_rd_data_valid && !tag_empty;
  assign pop_tag = rd_tag_t'(pop_bits);

  mem_rd_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_push),
    .tag_i   (tag_q),
    .pop_i   (tag_pop),
    .tag_o   (pop_bits),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      en_q       <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= '0;
      wdata_q    <= '0;
      mask_q     <= 16'hFFFF;
      tag_q      <= '0;
      rs_valid_q <= '0;
      rs_data_q  <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      en_q       <= en_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      tag_q      <= tag_d;
      rs_valid_q <= rs_valid_d;
      rs_data_q  <= rs_data_d;
      orphan_q   <= orphan_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    en_d       = en_q;
    wren_d     = wren_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    tag_d      = tag_q;
    rs_valid_d = '0;
    rs_data_d  = rs_data_q;
    orphan_d   = orphan_q;
    rq_ready   = '0;
    tag_push   = 1'b0;

    if (app_rd_data_valid) begin
      if (tag_empty) begin
        orphan_d = 1'b1;
      end else begin
        rs_valid_d[pop_tag.id] = 1'b1;
        rs_data_d              = extract_data(app_rd_data, pop_tag.off, pop_tag.width);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          rq_ready[win] = 1'b1;
          last_d        = win;
          en_d          = 1'b1;
          addr_d        = ADDR_WIDTH'({rq_addr[win][REQ_ADDR_WIDTH-1:4], 3'b000});
          tag_d         = '{id: win, off: win_off, width: rq_width[win]};
          if (rq_wr[win]) begin
            cmd_d   = CMD_WRITE;
            wdata_d = place_data(win_off, rq_width[win], rq_wr_data[win]);
            mask_d  = place_mask(win_off, rq_width[win]);
            wren_d  = 1'b1;
            state_d = ST_WR;
          end else begin
            cmd_d   = CMD_READ;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (app_rdy) begin
          en_d     = 1'b0;
          tag_push = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WR: begin
        // Command and data channels complete independently, in either order.
        if (app_rdy)     en_d   = 1'b0;
        if (app_wdf_rdy) wren_d = 1'b0;
        if (!en_d && !wren_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign app_en       = en_q;
  assign app_cmd      = cmd_q;
  assign app_addr     = addr_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = mask_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign rs_valid     = rs_valid_q;
  assign rs_data      = rs_data_q;
  assign err_orphan   = orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: directed and randomized checks against a byte-lane model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int TAG_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              calib_done;
  logic [1:0]        rq_valid;
  logic [1:0]        rq_wr;
  logic [1:0][25:0]  rq_addr;
  logic [1:0][1:0]   rq_width;
  logic [1:0][31:0]  rq_wr_data;
  logic [1:0]        rq_ready;
  logic [1:0]        rs_valid;
  logic [31:0]       rs_data;
  logic [28:0]       app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [127:0]      app_wdf_data;
  logic [15:0]       app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [127:0]      app_rd_data;
  logic              app_rd_data_valid;
  logic              err_orphan;

  mem_arbiter #(
    .ADDR_WIDTH     (29),
    .REQ_ADDR_WIDTH (26),
    .TAG_DEPTH      (TAG_DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .calib_done        (calib_done),
    .rq_valid          (rq_valid),
    .rq_wr             (rq_wr),
    .rq_addr           (rq_addr),
    .rq_width          (rq_width),
    .rq_wr_data        (rq_wr_data),
    .rq_ready          (rq_ready),
    .rs_valid          (rs_valid),
    .rs_data           (rs_data),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask      (app_wdf_mask),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .err_orphan        (err_orphan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one command in flight at most, and a plain queue of outstanding reads.
  typedef struct {
    int id;
    int off;
    int n;
  } mtag_t;

  mtag_t        m_q[$];
  mtag_t        m_tag;
  bit           m_busy;
  bit           m_iswr;
  int           m_last;
  logic         m_en, m_wren, m_orph;
  logic [28:0]  m_addr;
  logic [2:0]   m_cmd;
  logic [127:0] m_wd;
  logic [15:0]  m_mask;
  logic [1:0]   m_rsv;
  logic [31:0]  m_rsd;
  logic [1:0]   m_acc;
  logic [1:0]   d_rdy;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b11) ? 4 : (w == 2'b10) ? 2 : (w == 2'b01) ? 1 : 0;
  endfunction

  function automatic int lane_off(input logic [25:0] a, input logic [1:0] w);
    int o;
    int n;
    o = int'(a % 16);
    n = nbytes(w);
    if (n > 1) o = o - (o % n);
    return o;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy = 0;
    m_iswr = 0;
    m_last = 1;
    m_en   = 0;
    m_wren = 0;
    m_orph = 0;
    m_rsv  = 0;
    m_acc  = 0;
  endtask

  task automatic model_comb(output logic [1:0] er);
    int w;
    er = 2'b00;
    if (!rst && !m_busy && calib_done) begin
      if (rq_valid == 2'b11) w = (m_last == 1) ? 0 : 1;
      else                   w = rq_valid[1] ? 1 : 0;
      if (rq_valid[w] && (rq_wr[w] || m_q.size() < TAG_DEPTH)) er[w] = 1'b1;
    end
  endtask

  task automatic model_seq(input logic [1:0] er);
    mtag_t      t;
    logic [7:0] b;
    int         g;
    int         n;
    int         off;
    if (rst) begin
      m_reset();
      return;
    end
    m_rsv = 0;
    if (app_rd_data_valid) begin
      if (m_q.size() > 0) begin
        t = m_q.pop_front();
        m_rsv[t.id] = 1'b1;
        m_rsd = 0;
        for (int k = 0; k < t.n; k++) begin
          b     = 8'(app_rd_data >> (8 * (t.off + k)));
          m_rsd = m_rsd | (32'(b) << (8 * (3 - k)));
        end
      end else begin
        m_orph = 1;
      end
    end
    if (m_busy) begin
      if (!m_iswr) begin
        if (app_rdy) begin
          m_q.push_back(m_tag);
          m_en   = 0;
          m_busy = 0;
        end
      end else begin
        if (app_rdy)     m_en   = 0;
        if (app_wdf_rdy) m_wren = 0;
        if (!m_en && !m_wren) m_busy = 0;
      end
    end else if (er != 2'b00) begin
      g      = er[1] ? 1 : 0;
      n      = nbytes(rq_width[g]);
      off    = lane_off(rq_addr[g], rq_width[g]);
      m_last = g;
      m_busy = 1;
      m_iswr = rq_wr[g];
      m_en   = 1;
      m_addr = 29'((rq_addr[g] >> 4) << 3);
      m_tag  = '{id: g, off: off, n: n};
      if (rq_wr[g]) begin
        m_cmd  = 3'b000;
        m_wren = 1;
        m_wd   = 0;
        m_mask = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
          b          = 8'(rq_wr_data[g] >> (8 * (n - 1 - k)));
          m_wd       = m_wd | (128'(b) << (8 * (off + k)));
          m_mask[off + k] = 1'b0;
        end
      end else begin
        m_cmd = 3'b001;
      end
    end
  endtask

  task automatic chk_regs();
    chk("app_en", app_en, m_en);
    chk("app_wdf_wren", app_wdf_wren, m_wren);
    chk("app_wdf_end", app_wdf_end, m_wren);
    chk("rs_valid", rs_valid, m_rsv);
    chk("err_orphan", err_orphan, m_orph);
    if (m_en) begin
      chk("app_addr", app_addr, m_addr);
      chk("app_cmd", app_cmd, m_cmd);
    end
    if (m_wren) begin
      chk("app_wdf_data", app_wdf_data, m_wd);
      chk("app_wdf_mask", app_wdf_mask, m_mask);
    end
    if (m_rsv != 2'b00) chk("rs_data", rs_data, m_rsd);
  endtask

  // Inputs are set at a falling edge; this settles, checks, models the rising edge, and returns at the next falling edge.
  task automatic tick();
    logic [1:0] er;
    #1;
    model_comb(er);
    d_rdy = rq_ready;
    chk("rq_ready", rq_ready, er);
    m_acc = er;
    model_seq(er);
    @(negedge clk);
    chk_regs();
  endtask

  task automatic issue(input int i, input bit wr, input logic [25:0] a, input logic [1:0] w,
                       input logic [31:0] d);
    int b;
    b             = 0;
    rq_valid[i]   = 1'b1;
    rq_wr[i]      = wr;
    rq_addr[i]    = a;
    rq_width[i]   = w;
    rq_wr_data[i] = d;
    do begin
      tick();
      b++;
    end while (!m_acc[i] && b < 20);
    chk("accept", d_rdy[i], 1'b1);
    rq_valid[i] = 1'b0;
  endtask

  task automatic settle();
    int b;
    b           = 0;
    rq_valid    = 2'b00;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    while (m_busy && b < 20) begin
      tick();
      b++;
    end
    chk("settle", {app_en, app_wdf_wren}, 2'b00);
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (m_q.size() > 0 && b < 20) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      b++;
    end
    app_rd_data_valid = 1'b0;
    chk("drain", m_q.size() == 0, 1'b1);
  endtask

  int gseq[4];
  int ng;
  int bnd;

  initial begin
    rst = 1'b1; calib_done = 1'b0;
    rq_valid = '0; rq_wr = '0; rq_addr = '0; rq_width = '0; rq_wr_data = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
    m_reset();
    @(negedge clk);
    tick();
    tick();
    chk("reset_mask", app_wdf_mask, 16'hFFFF);
    chk("reset_outs", {app_en, app_wdf_wren, app_wdf_end, rs_valid, rq_ready, err_orphan}, 8'h00);
    chk("reset_addr_cmd", {app_addr, app_cmd}, 32'h0);
    chk("reset_data", {app_wdf_data, rs_data}, 160'h0);

    // Contention: nothing issues while uncalibrated, then grants alternate starting with requester 0.
    rst = 1'b0;
    rq_valid = 2'b11; rq_wr = 2'b11;
    rq_addr[0] = 26'h100; rq_addr[1] = 26'h204;
    rq_width[0] = 2'b11; rq_width[1] = 2'b10;
    rq_wr_data[0] = 32'hDEADBEEF; rq_wr_data[1] = 32'h0000CAFE;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("calib_hold_en", app_en, 1'b0);
    end
    calib_done = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int k = 0; k < 4; k++) gseq[k] = -1;
    ng = 0; bnd = 0;
    while (ng < 4 && bnd < 40) begin
      tick();
      if (d_rdy[0]) begin gseq[ng] = 0; ng++; end
      else if (d_rdy[1]) begin gseq[ng] = 1; ng++; end
      bnd++;
    end
    for (int k = 0; k < 4; k++) chk("grant_order", 128'(gseq[k]), 128'(k % 2));
    settle();

    // Byte write 0xAB at 0x13: burst at byte 0x10, lane 3.
    issue(0, 1'b1, 26'h13, 2'b01, 32'h000000AB);
    chk("byte_wr_addr", app_addr, 29'h8);
    chk("byte_wr_cmd", app_cmd, 3'b000);
    chk("byte_wr_mask", app_wdf_mask, 16'hFFF7);
    chk("byte_wr_lane3", app_wdf_data[31:24], 8'hAB);
    settle();

    // 32-bit read at 0x10; lanes 0..3 = 11 22 33 AB.
    issue(0, 1'b0, 26'h10, 2'b11, 32'h0);
    settle();
    app_rd_data = 128'hAB332211; app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    chk("rd32_valid", rs_valid, 2'b01);
    chk("rd32_data", rs_data, 32'h112233AB);
    chk("rd32_low_byte", rs_data[7:0], 8'hAB);

    // 16-bit write at 0x0F aligns to lane 14.
    issue(1, 1'b1, 26'h0F, 2'b10, 32'h00001234);
    chk("h16_mask", app_wdf_mask, 16'h3FFF);
    chk("h16_lanes", app_wdf_data[127:112], 16'h3412);
    chk("h16_addr", app_addr, 29'h0);
    settle();

    // Data channel accepted first, then command three cycles later.
    issue(0, 1'b1, 26'h40, 2'b11, 32'hA1B2C3D4);
    app_wdf_rdy = 1'b1;
    tick();
    app_wdf_rdy = 1'b0;
    chk("skew_wren_drop", app_wdf_wren, 1'b0);
    chk("skew_en_hold", app_en, 1'b1);
    tick(); tick();
    chk("skew_en_hold2", app_en, 1'b1);
    app_rdy = 1'b1;
    tick();
    app_rdy = 1'b0;
    chk("skew_en_drop", app_en, 1'b0);
    // Reverse order.
    issue(1, 1'b1, 26'h55, 2'b01, 32'h0000005A);
    app_rdy = 1'b1;
    tick();
    app_rdy = 1'b0;
    chk("rskew_en_drop", app_en, 1'b0);
    chk("rskew_wren_hold", app_wdf_wren, 1'b1);
    tick(); tick();
    chk("rskew_wren_hold2", app_wdf_wren, 1'b1);
    app_wdf_rdy = 1'b1;
    tick();
    app_wdf_rdy = 1'b0;
    chk("rskew_wren_drop", app_wdf_wren, 1'b0);

    // Fill the tag store with stalled reads, then a fifth read waits for a pop.
    for (int r = 0; r < 4; r++) begin
      issue(r % 2, 1'b0, 26'(r * 16 + r * 5), 2'(3 - r), 32'h0);
      app_rdy = 1'b0;
      tick(); tick();
      settle();
    end
    rq_valid[1] = 1'b1; rq_wr[1] = 1'b0; rq_addr[1] = 26'h80; rq_width[1] = 2'b11;
    app_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("tag_full_stall", d_rdy[1], 1'b0);
    end
    app_rd_data = 128'h0F0E0D0C0B0A09080706050403020100; app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    chk("first_pop_id", rs_valid, 2'b01);
    chk("first_pop_data", rs_data, 32'h00010203);
    chk("stall_release", rq_ready[1], 1'b1);
    tick();
    settle();
    drain();

    // Randomized traffic with calibration dropouts and handshake stalls.
    rq_valid = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i] || !rq_valid[i]) begin
          if ($urandom_range(0, 9) < 7) begin
            rq_valid[i]   = 1'b1;
            rq_wr[i]      = 1'($urandom_range(0, 1));
            rq_addr[i]    = 26'($urandom);
            rq_width[i]   = 2'($urandom_range(0, 3));
            rq_wr_data[i] = $urandom;
          end else begin
            rq_valid[i] = 1'b0;
          end
        end
      end
      calib_done  = ($urandom_range(0, 29) != 0);
      app_rdy     = ($urandom_range(0, 3) != 0);
      app_wdf_rdy = ($urandom_range(0, 3) != 0);
      if (m_q.size() > 0 && $urandom_range(0, 3) == 0) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        app_rd_data_valid = 1'b0;
      end
      tick();
    end
    app_rd_data_valid = 1'b0;
    calib_done = 1'b1;
    settle();
    drain();

    // Read data with nothing outstanding.
    app_rd_data = {4{32'h5A5A5A5A}}; app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    chk("orphan_set", err_orphan, 1'b1);
    chk("orphan_no_rs", rs_valid, 2'b00);
    tick();
    chk("orphan_sticky", err_orphan, 1'b1);

    // Reset while a read command is held.
    app_rdy = 1'b0;
    issue(0, 1'b0, 26'h123, 2'b11, 32'h0);
    tick();
    chk("rd_held", app_en, 1'b1);
    rq_valid[0] = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_outs", {app_en, app_wdf_wren, app_wdf_end, rs_valid, rq_ready, err_orphan}, 8'h00);
    chk("rst_addr_cmd", {app_addr, app_cmd}, 32'h0);
    chk("rst_mask", app_wdf_mask, 16'hFFFF);
    chk("rst_rs_data", rs_data, 32'h0);
    rst = 1'b0; rq_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
